// File: rtl/pt2262_pkg.sv
// Shared PT2262 encoder definitions: FSM states, frame geometry and trit codes.
// Also used by the address-code generator and the decoder side.
package pt2262_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    SYNC = 2'd2
  } state_e;

  localparam int HALFBITS_PER_FRAME = 24;
  localparam int ALPHA_PER_HALFBIT  = 16;
  localparam int SHORT_ALPHA        = 4;
  localparam int LONG_ALPHA         = 12;
  localparam int SYNC_HIGH_ALPHA    = 4;

  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b11;
  localparam logic [1:0] TRIT_F = 2'b01;

  // Data bits become 00/11 trits above the address, D0 nearest the address.
  function automatic logic [23:0] pack_frame(input logic [15:0] ax, input logic [3:0] d);
    return {{2{d[3]}}, {2{d[2]}}, {2{d[1]}}, {2{d[0]}}, ax};
  endfunction

endpackage

// File: rtl/pt2262_serializer_prescaler.sv
// Alpha prescaler: divides clk into oscillator periods, alpha_tick on terminal count.
// Held at zero while clear is high.
module alpha_prescaler #(
  parameter int CLK_PER_ALPHA = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic alpha_tick
);

  generate
    if (CLK_PER_ALPHA <= 1) begin : g_direct
      assign alpha_tick = 1'b1;
    end else begin : g_count
      localparam int CW = $clog2(CLK_PER_ALPHA);
      localparam logic [CW-1:0] LAST = CW'(CLK_PER_ALPHA - 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clear || cnt == LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign alpha_tick = (cnt == LAST) && !clear;
    end
  endgenerate

endmodule

// File: rtl/pt2262_serializer.sv
// PT2262 on-air serializer: 24 half-bits of 16 alpha each, then a 4-alpha-high sync word.
// PT2262_MIN_REPEAT_EN: guarantee at least four frames per te assertion.
module pt2262_serializer
  import pt2262_pkg::*;
#(
  parameter int CLK_PER_ALPHA  = 16,
  parameter int SYNC_LOW_ALPHA = 124
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Ax,
  input  logic [3:0]  D,
  input  logic        te,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int SYNC_LEN = SYNC_HIGH_ALPHA + SYNC_LOW_ALPHA;
  localparam int AW = $clog2(SYNC_LEN > ALPHA_PER_HALFBIT ? SYNC_LEN : ALPHA_PER_HALFBIT);
  localparam logic [AW-1:0] HB_LAST_A   = AW'(ALPHA_PER_HALFBIT - 1);
  localparam logic [AW-1:0] SYNC_LAST_A = AW'(SYNC_LEN - 1);
  localparam logic [AW-1:0] SHORT_A     = AW'(SHORT_ALPHA);
  localparam logic [AW-1:0] LONG_A      = AW'(LONG_ALPHA);
  localparam logic [AW-1:0] SYNC_HIGH_A = AW'(SYNC_HIGH_ALPHA);
  localparam logic [4:0]    HB_LAST     = 5'(HALFBITS_PER_FRAME - 1);

  state_e        state, state_n;
  logic [23:0]   frame, frame_n;
  logic [4:0]    hb, hb_n;
  logic [AW-1:0] acnt, acnt_n;
  logic          dout_n;
  logic          alpha_tick;
  logic          sync_end;
  logic          again;

  alpha_prescaler #(.CLK_PER_ALPHA(CLK_PER_ALPHA)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE),
    .alpha_tick (alpha_tick)
  );

  assign sync_end   = (state == SYNC) && alpha_tick && (acnt == SYNC_LAST_A);
  assign frame_done = sync_end;

`ifdef PT2262_MIN_REPEAT_EN
  logic [1:0] rep;

  assign again = te || (rep != 2'd3);

  // Counts completed frames of the current burst; cleared when the burst ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep <= 2'd0;
    end else if (sync_end) begin
      if (!again)              rep <= 2'd0;
      else if (rep != 2'd3)    rep <= rep + 2'd1;
    end
  end
`else
  assign again = te;
`endif

  always_comb begin
    state_n = state;
    frame_n = frame;
    hb_n    = hb;
    acnt_n  = acnt;
    case (state)
      IDLE: begin
        if (te) begin
          state_n = BITS;
          frame_n = pack_frame(Ax, D);
          hb_n    = '0;
          acnt_n  = '0;
        end
      end
      BITS: begin
        if (alpha_tick) begin
          if (acnt == HB_LAST_A) begin
            acnt_n = '0;
            if (hb == HB_LAST) state_n = SYNC;
            else               hb_n = hb + 5'd1;
          end else begin
            acnt_n = acnt + AW'(1);
          end
        end
      end
      SYNC: begin
        if (alpha_tick) begin
          if (acnt == SYNC_LAST_A) begin
            acnt_n = '0;
            hb_n   = '0;
            if (again) begin
              state_n = BITS;
              frame_n = pack_frame(Ax, D);
            end else begin
              state_n = IDLE;
            end
          end else begin
            acnt_n = acnt + AW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        hb_n    = '0;
        acnt_n  = '0;
      end
    endcase
  end

  // dout is computed for the position being entered so it is registered, not decoded.
  always_comb begin
    dout_n = 1'b0;
    case (state_n)
      BITS:    dout_n = acnt_n < (frame_n[hb_n ^ 5'd1] ? LONG_A : SHORT_A);
      SYNC:    dout_n = acnt_n < SYNC_HIGH_A;
      default: dout_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      hb    <= '0;
      acnt  <= '0;
      dout  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      frame <= frame_n;
      hb    <= hb_n;
      acnt  <= acnt_n;
      dout  <= dout_n;
      busy  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_pt2262_serializer.sv
// Bench for pt2262_serializer: waveform model checked every cycle plus directed literal checks.
// Honours PT2262_MIN_REPEAT_EN when the build defines it.
module tb_pt2262_serializer;

  localparam int CPA         = 2;
  localparam int SYNC_LOW    = 124;
  localparam int FRAME_ALPHA = 24 * 16 + 4 + SYNC_LOW;
  localparam int FRAME_CLK   = FRAME_ALPHA * CPA;
`ifdef PT2262_MIN_REPEAT_EN
  localparam int MIN_FRAMES = 4;
`else
  localparam int MIN_FRAMES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ax  = '0;
  logic [3:0]  d   = '0;
  logic        te  = 1'b0;
  logic        dout, busy, frame_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_last = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pt2262_serializer #(.CLK_PER_ALPHA(CPA), .SYNC_LOW_ALPHA(SYNC_LOW)) dut (
    .clk        (clk),
    .rst        (rst),
    .Ax         (ax),
    .D          (d),
    .te         (te),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected line level t clocks into a frame, straight from the on-air timing rules.
  function automatic logic level(input logic [15:0] a, input logic [3:0] dd, input int t);
    int alpha, hb, pos;
    logic b;
    alpha = t / CPA;
    if (alpha < 384) begin
      hb  = alpha / 16;
      pos = alpha % 16;
      if (hb < 16) b = a[(hb / 2) * 2 + ((hb % 2 == 0) ? 1 : 0)];
      else         b = dd[(hb - 16) / 2];
      return pos < (b ? 12 : 4);
    end
    return (alpha - 384) < 4;
  endfunction

  logic        m_busy = 1'b0;
  int          m_t = 0;
  int          m_frames = 0;
  logic [15:0] m_ax = '0;
  logic [3:0]  m_d = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_t = 0;
      m_frames = 0;
    end else if (!m_busy) begin
      if (te) begin
        m_busy = 1'b1; m_t = 0; m_frames = 1; m_ax = ax; m_d = d;
      end
    end else if (m_t == FRAME_CLK - 1) begin
      if (te || m_frames < MIN_FRAMES) begin
        m_t = 0; m_frames++; m_ax = ax; m_d = d;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    logic ed;
    ed = m_busy ? level(m_ax, m_d, m_t) : 1'b0;
    check("model_dout", dout, ed);
    check("model_busy", busy, m_busy);
    check("model_frame_done", frame_done, m_busy && (m_t == FRAME_CLK - 1));
    if (frame_done) begin
      fd_count++;
      fd_last = cyc;
    end
  end

  task automatic start(input logic [15:0] a, input logic [3:0] dd, input bit hold, output int s);
    @(negedge clk);
    ax = a; d = dd; te = 1'b1;
    @(negedge clk);
    s = cyc;
    if (!hold) te = 1'b0;
  endtask

  task automatic go_to(input int s, input int off);
    while (cyc < s + off) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    int s, fd0;
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // All-zero frame, te for one clock
    fd0 = fd_count;
    start(16'h0000, 4'h0, 1'b0, s);
    check("a_first_high", dout, 1);
    check("a_busy_up", busy, 1);
    go_to(s, 7);    check("a_alpha3_high", dout, 1);
    go_to(s, 8);    check("a_alpha4_low", dout, 0);
    go_to(s, 40);   check("a_hb1_short", dout, 0);
    go_to(s, 768);  check("a_sync_high", dout, 1);
    go_to(s, 776);  check("a_sync_low", dout, 0);
    go_to(s, 1023); check("a_frame_done", frame_done, 1);
    go_to(s, 1024);
    check("a_busy_after", busy, (MIN_FRAMES == 1) ? 0 : 1);
    check("a_fd_offset", fd_last - s, 1023);
    wait_idle(MIN_FRAMES * FRAME_CLK + 16, "a_idle_timeout");
    check("a_fd_count", fd_count - fd0, MIN_FRAMES);

    // All-F address, all-one data
    start(16'h5555, 4'hF, 1'b0, s);
    go_to(s, 8);   check("b_f_short_half", dout, 0);
    go_to(s, 40);  check("b_f_long_half", dout, 1);
    go_to(s, 534); check("b_d0_alpha11", dout, 1);
    go_to(s, 536); check("b_d0_alpha12", dout, 0);
    wait_idle(MIN_FRAMES * FRAME_CLK + 16, "b_idle_timeout");

    // Address change mid-frame only shows in the next frame
    start(16'h0000, 4'h0, 1'b1, s);
    go_to(s, 101); ax = 16'hFFFF;
    go_to(s, 200);  check("c_frame1_unchanged", dout, 0);
    go_to(s, 1024); check("c_no_gap_busy", busy, 1);
    go_to(s, 1032); check("c_frame2_new_addr", dout, 1);
    te = 1'b0;
    wait_idle(4 * FRAME_CLK + 16, "c_idle_timeout");

    // te held for three frames, dropped at half-bit 10 of frame 3
    fd0 = fd_count;
    start(16'h1234, 4'h9, 1'b1, s);
    go_to(s, 2 * FRAME_CLK + 10 * 32 + 5);
    te = 1'b0;
    go_to(s, 3 * FRAME_CLK - 1); check("d_frame3_running", busy, 1);
    wait_idle(4 * FRAME_CLK + 16, "d_idle_timeout");
    check("d_fd_count", fd_count - fd0, (MIN_FRAMES > 3) ? MIN_FRAMES : 3);
    check("d_dout_idle", dout, 0);

    // Asynchronous reset at half-bit 5
    start(16'h00FF, 4'h3, 1'b0, s);
    go_to(s, 165);
    check("e_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("e_async_dout", dout, 0);
    check("e_async_busy", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (50) @(negedge clk);
    check("e_stays_idle", busy, 0);
    check("e_dout_idle", dout, 0);

    // Single-clock te pulse: frame count per burst
    fd0 = fd_count;
    start(16'hA5C3, 4'h6, 1'b0, s);
    wait_idle(5 * FRAME_CLK, "f_idle_timeout");
    check("f_fd_count", fd_count - fd0, MIN_FRAMES);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
